pseudo_spi_rx: RTL and testbench

- Receive-side partner of the pseudo-SPI transmitter in the SCPU_8bit subsystem.
- On CPU request (io_control SPI-read bit), generates SEL/SCLK1/SCLK2 toward the analog serial chain and shifts in SPI_SI MSB-first.
- Assembles each byte and writes it to SRAM through the same CEN/D_WE/A/PO mux path the transmitter uses.
- Raises spi_is_done for the CPU's io_status after DATA_LEN bytes.

---
 rtl/pseudo_spi_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_pseudo_spi_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pseudo_spi_rx.sv
// -----------------------------------------------------------------------------
// pseudo_spi_rx
// Receive-side partner of the pseudo-SPI transmitter. On a level request (BGN)
// it drives SEL/SCLK1/SCLK2 toward the analog serial chain and shifts SPI_SI
// in MSB-first. Each received byte is written to SRAM through CEN/D_WE/A/PO.
// spi_is_done rises after DATA_LEN bytes and stays high until BGN drops.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous reset, active-high
//   BGN          level request, held high for the whole transfer
//   ADDR_BGN     first SRAM address written (latched at start)
//   DATA_LEN     number of bytes to receive (latched at start)
//   FREQ_DIV     phase stretch factor minus one (only with the macro below)
//   SPI_SI       serial data from the analog chain
//   SCLK1/SCLK2  non-overlapping two-phase shift clocks
//   SEL          load/select strobe, high for the LOAD phase before each frame
//   CEN          SRAM chip enable, active-low
//   D_WE         SRAM write request, 1 = write
//   A / PO       SRAM address / write data
//   spi_is_done  transfer complete, level
//
// Optional feature macro: PSEUDO_SPI_RX_FREQ_DIV_EN adds the FREQ_DIV input.
// Without it every SCLK phase and LOAD cycle lasts exactly one CLK cycle.
// -----------------------------------------------------------------------------
module pseudo_spi_rx #(
   parameter int MEMORY_ADDR_WIDTH = 9,
   parameter int MEMORY_DATA_WIDTH = 8,
   parameter int RESERVED_DATA_LEN = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         BGN,
   input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
   input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
   input  logic [1:0]                   FREQ_DIV,
`endif
   input  logic                         SPI_SI,
   output logic                         SCLK1,
   output logic                         SCLK2,
   output logic                         SEL,
   output logic                         CEN,
   output logic                         D_WE,
   output logic [MEMORY_ADDR_WIDTH-1:0] A,
   output logic [MEMORY_DATA_WIDTH-1:0] PO,
   output logic                         spi_is_done
);

   localparam int BIT_W = (MEMORY_DATA_WIDTH > 1) ? $clog2(MEMORY_DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MEMORY_DATA_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WRITE, S_DONE} state_t;

   state_t                         r_state, w_state_next;
   logic [1:0]                     r_div, w_div_next;      // stretch counter inside a phase
   logic [1:0]                     r_phase, w_phase_next;  // LOAD: 0..1, SHIFT: ph0..ph3
   logic [BIT_W-1:0]               r_bit, w_bit_next;
   logic [RESERVED_DATA_LEN-1:0]   r_cnt, w_cnt_next;
   logic [RESERVED_DATA_LEN-1:0]   r_len, w_len_next;
   logic [1:0]                     r_fdiv, w_fdiv_next;
   logic [MEMORY_DATA_WIDTH-1:0]   r_shift, w_shift_next;
   logic [MEMORY_ADDR_WIDTH-1:0]   r_addr, w_addr_next;
   logic [MEMORY_DATA_WIDTH-1:0]   r_po, w_po_next;
   logic r_sclk1, r_sclk2, r_sel, r_cen, r_dwe, r_done;
   logic w_sclk1_next, w_sclk2_next, w_sel_next, w_cen_next, w_dwe_next, w_done_next;

   logic [1:0]                     w_fdiv_in;
   logic                           w_tick;
   logic [RESERVED_DATA_LEN-1:0]   w_cnt_inc;

`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
   assign w_fdiv_in = FREQ_DIV;
`else
   assign w_fdiv_in = 2'd0;
`endif

   // Last CLK cycle of the current (possibly stretched) phase.
   assign w_tick    = (r_div == r_fdiv);
   assign w_cnt_inc = r_cnt + RESERVED_DATA_LEN'(1);

   // State register; outputs are registered alongside it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_phase <= '0;
         r_bit   <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_fdiv  <= '0;
         r_shift <= '0;
         r_addr  <= '0;
         r_po    <= '0;
         r_sclk1 <= 1'b0;
         r_sclk2 <= 1'b0;
         r_sel   <= 1'b0;
         r_cen   <= 1'b1;
         r_dwe   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_div   <= w_div_next;
         r_phase <= w_phase_next;
         r_bit   <= w_bit_next;
         r_cnt   <= w_cnt_next;
         r_len   <= w_len_next;
         r_fdiv  <= w_fdiv_next;
         r_shift <= w_shift_next;
         r_addr  <= w_addr_next;
         r_po    <= w_po_next;
         r_sclk1 <= w_sclk1_next;
         r_sclk2 <= w_sclk2_next;
         r_sel   <= w_sel_next;
         r_cen   <= w_cen_next;
         r_dwe   <= w_dwe_next;
         r_done  <= w_done_next;
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div;
      w_phase_next = r_phase;
      w_bit_next   = r_bit;
      w_cnt_next   = r_cnt;
      w_len_next   = r_len;
      w_fdiv_next  = r_fdiv;
      w_shift_next = r_shift;
      w_addr_next  = r_addr;
      w_po_next    = r_po;
      unique case (r_state)
         S_IDLE: begin
            if (BGN) begin
               w_len_next   = DATA_LEN;
               w_fdiv_next  = w_fdiv_in;
               w_addr_next  = ADDR_BGN;
               w_cnt_next   = '0;
               w_div_next   = '0;
               w_phase_next = '0;
               w_bit_next   = '0;
               w_state_next = (DATA_LEN == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (!BGN) begin
               w_state_next = S_IDLE;
            end else if (w_tick) begin
               w_div_next = '0;
               if (r_phase == 2'd1) begin
                  w_state_next = S_SHIFT;
                  w_phase_next = '0;
                  w_bit_next   = '0;
               end else begin
                  w_phase_next = r_phase + 2'd1;
               end
            end else begin
               w_div_next = r_div + 2'd1;
            end
         end
         S_SHIFT: begin
            if (!BGN) begin
               w_state_next = S_IDLE;
            end else if (w_tick) begin
               w_div_next = '0;
               if (r_phase == 2'd3) begin
                  // Sample on the edge that ends ph3; first sample lands in the MSB.
                  w_shift_next = {r_shift[MEMORY_DATA_WIDTH-2:0], SPI_SI};
                  w_phase_next = '0;
                  if (r_bit == LAST_BIT) begin
                     w_state_next = S_WRITE;
                     w_po_next    = w_shift_next;
                  end else begin
                     w_bit_next = r_bit + BIT_W'(1);
                  end
               end else begin
                  w_phase_next = r_phase + 2'd1;
               end
            end else begin
               w_div_next = r_div + 2'd1;
            end
         end
         S_WRITE: begin
            if (!BGN) begin
               w_state_next = S_IDLE;
            end else begin
               w_addr_next  = r_addr + MEMORY_ADDR_WIDTH'(1);
               w_cnt_next   = w_cnt_inc;
               w_phase_next = '0;
               w_div_next   = '0;
               w_state_next = (w_cnt_inc == r_len) ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            if (!BGN) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every pin is a flop.
   // done is set on the WRITE->DONE edge, or one cycle into DONE for a
   // zero-length request, and held while DONE continues.
   always_comb begin
      w_sel_next   = (w_state_next == S_LOAD);
      w_sclk1_next = (w_state_next == S_SHIFT) && (w_phase_next == 2'd0);
      w_sclk2_next = (w_state_next == S_SHIFT) && (w_phase_next == 2'd2);
      w_cen_next   = (w_state_next != S_WRITE);
      w_dwe_next   = (w_state_next == S_WRITE);
      w_done_next  = (w_state_next == S_DONE) &&
                     ((r_state == S_WRITE) || (r_state == S_DONE));
   end

   assign SCLK1       = r_sclk1;
   assign SCLK2       = r_sclk2;
   assign SEL         = r_sel;
   assign CEN         = r_cen;
   assign D_WE        = r_dwe;
   assign A           = r_addr;
   assign PO          = r_po;
   assign spi_is_done = r_done;

endmodule

// File: tb/tb_pseudo_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_pseudo_spi_rx
// Directed bench for pseudo_spi_rx. A behavioural serial chain loads a byte on
// each SEL rise and presents it MSB-first, shifting on every SCLK1 rise after
// the first of a frame. Expected SRAM writes are queued when stimulus is set
// up; a monitor records observed writes and pin activity on the falling edge.
// -----------------------------------------------------------------------------
module tb_pseudo_spi_rx;
   localparam int AW = 9;
   localparam int DW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          bgn = 1'b0;
   logic [AW-1:0] addr_bgn = '0;
   logic [LW-1:0] data_len = '0;
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
   logic [1:0]    freq_div = 2'd0;
`endif
   logic          spi_si;
   logic          sclk1, sclk2, sel, cen, d_we, spi_is_done;
   logic [AW-1:0] a;
   logic [DW-1:0] po;

   always #5 clk = ~clk;

   pseudo_spi_rx #(
      .MEMORY_ADDR_WIDTH(AW),
      .MEMORY_DATA_WIDTH(DW),
      .RESERVED_DATA_LEN(LW)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .BGN(bgn),
      .ADDR_BGN(addr_bgn),
      .DATA_LEN(data_len),
`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
      .FREQ_DIV(freq_div),
`endif
      .SPI_SI(spi_si),
      .SCLK1(sclk1),
      .SCLK2(sclk2),
      .SEL(sel),
      .CEN(cen),
      .D_WE(d_we),
      .A(a),
      .PO(po),
      .spi_is_done(spi_is_done)
   );

   logic [7:0]       src_q[$];   // bytes the analog chain will present
   logic [AW+DW-1:0] exp_q[$];   // expected {A,PO} writes
   logic [AW+DW-1:0] obs_q[$];   // observed {A,PO} writes

   // Analog serial chain model.
   logic [7:0] chain = 8'h00;
   logic       first = 1'b0;
   always @(posedge sel or posedge sclk1) begin
      if (sel) begin
         chain = (src_q.size() > 0) ? src_q.pop_front() : 8'h00;
         first = 1'b1;
      end else if (first) begin
         first = 1'b0;
      end else begin
         chain = {chain[6:0], 1'b0};
      end
   end
   assign spi_si = chain[7];

   // Pin activity monitor.
   int n_sel_cyc = 0, n_sel_rise = 0, n_s1 = 0, n_s2 = 0, n_ovl = 0;
   int n_cen_low = 0, n_bad = 0, run1 = 0, run2 = 0, w1 = 0, w2 = 0;
   logic p_sel = 1'b0, p1 = 1'b0, p2 = 1'b0;
   always @(negedge clk) begin
      if (sel === 1'b1) n_sel_cyc++;
      if (sel === 1'b1 && !p_sel) n_sel_rise++;
      if (sclk1 === 1'b1 && !p1) n_s1++;
      if (sclk2 === 1'b1 && !p2) n_s2++;
      if (sclk1 === 1'b1 && sclk2 === 1'b1) n_ovl++;
      if (sclk1 === 1'b1) run1++; else if (p1) begin w1 = run1; run1 = 0; end
      if (sclk2 === 1'b1) run2++; else if (p2) begin w2 = run2; run2 = 0; end
      if (cen === 1'b0) n_cen_low++;
      if (!rst && ((cen === 1'b0) !== (d_we === 1'b1))) n_bad++;
      if (cen === 1'b0 && d_we === 1'b1) obs_q.push_back({a, po});
      p_sel = (sel === 1'b1);
      p1    = (sclk1 === 1'b1);
      p2    = (sclk2 === 1'b1);
   end

   int n_checks = 0;
   int n_fail   = 0;
   int b_sel_cyc, b_sel_rise, b_s1, b_s2, b_ovl, b_cen_low;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_sel_cyc  = n_sel_cyc;
      b_sel_rise = n_sel_rise;
      b_s1       = n_s1;
      b_s2       = n_s2;
      b_ovl      = n_ovl;
      b_cen_low  = n_cen_low;
   endtask

   // BGN must already be high; the first step() is edge k.
   task automatic xfer_wait(input int e, input bit scramble, input string tag);
      int early;
      early = 0;
      for (int i = 0; i < e; i++) begin
         step();
         if (spi_is_done === 1'b1) early++;
         if (scramble && i == 4) begin
            addr_bgn = 9'h0AA;
            data_len = 8'd7;
         end
      end
      check({tag, " done early"}, early, 0);
      step();
      check({tag, " done"}, {31'b0, spi_is_done}, 1);
   endtask

   task automatic drain(input string tag);
      logic [AW+DW-1:0] o, e;
      int n;
      check({tag, " write count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         $display("%s write: A=0x%03h PO=0x%02h", tag, o[AW+DW-1:DW], o[DW-1:0]);
         check({tag, " addr"}, o[AW+DW-1:DW], e[AW+DW-1:DW]);
         check({tag, " data"}, o[DW-1:0], e[DW-1:0]);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " SCLK1"}, sclk1, 0);
      check({tag, " SCLK2"}, sclk2, 0);
      check({tag, " SEL"},   sel, 0);
      check({tag, " CEN"},   cen, 1);
      check({tag, " D_WE"},  d_we, 0);
      check({tag, " A"},     a, 0);
      check({tag, " PO"},    po, 0);
      check({tag, " done"},  spi_is_done, 0);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // Single byte 0xA5 at 0x040
      snap();
      src_q.push_back(8'hA5);
      exp_q.push_back({9'h040, 8'hA5});
      addr_bgn = 9'h040;
      data_len = 8'd1;
      bgn = 1'b1;
      xfer_wait(35, 1'b0, "t1");
      check("t1 sclk1 pulses", n_s1 - b_s1, 8);
      check("t1 sclk2 pulses", n_s2 - b_s2, 8);
      check("t1 overlap", n_ovl - b_ovl, 0);
      check("t1 sel cycles", n_sel_cyc - b_sel_cyc, 2);
      repeat (5) step();
      check("t1 hold done", spi_is_done, 1);
      bgn = 1'b0;
      step();
      check("t1 release done", spi_is_done, 0);
      drain("t1");

      // Three bytes with address wrap; inputs scrambled mid-transfer
      step();
      snap();
      src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
      exp_q.push_back({9'h1FE, 8'h11});
      exp_q.push_back({9'h1FF, 8'h22});
      exp_q.push_back({9'h000, 8'h33});
      addr_bgn = 9'h1FE;
      data_len = 8'd3;
      bgn = 1'b1;
      xfer_wait(105, 1'b1, "t2");
      check("t2 sel pulses", n_sel_rise - b_sel_rise, 3);
      check("t2 sclk1 pulses", n_s1 - b_s1, 24);
      check("t2 overlap", n_ovl - b_ovl, 0);
      bgn = 1'b0;
      step();
      check("t2 release done", spi_is_done, 0);
      drain("t2");

      // Zero length
      step();
      snap();
      addr_bgn = 9'h055;
      data_len = 8'd0;
      bgn = 1'b1;
      xfer_wait(1, 1'b0, "t3");
      repeat (3) step();
      check("t3 sel cycles", n_sel_cyc - b_sel_cyc, 0);
      check("t3 sclk1 pulses", n_s1 - b_s1, 0);
      check("t3 cen low", n_cen_low - b_cen_low, 0);
      bgn = 1'b0;
      step();
      check("t3 release done", spi_is_done, 0);
      drain("t3");

      // Abort in the middle of the 2nd of 4 bytes, then restart
      step();
      src_q.push_back(8'hC3); src_q.push_back(8'h5A);
      src_q.push_back(8'h0F); src_q.push_back(8'hF0);
      exp_q.push_back({9'h080, 8'hC3});
      addr_bgn = 9'h080;
      data_len = 8'd4;
      bgn = 1'b1;
      begin
         int early;
         early = 0;
         for (int i = 0; i < 50; i++) begin
            step();
            if (spi_is_done === 1'b1) early++;
         end
         check("t4 done before abort", early, 0);
      end
      bgn = 1'b0;
      step();
      check("t4 abort SCLK1", sclk1, 0);
      check("t4 abort SCLK2", sclk2, 0);
      check("t4 abort SEL", sel, 0);
      check("t4 abort CEN", cen, 1);
      check("t4 abort done", spi_is_done, 0);
      repeat (3) step();
      check("t4 done after abort", spi_is_done, 0);
      drain("t4");
      src_q.delete();
      src_q.push_back(8'h7E);
      exp_q.push_back({9'h0F0, 8'h7E});
      addr_bgn = 9'h0F0;
      data_len = 8'd1;
      bgn = 1'b1;
      xfer_wait(35, 1'b0, "t4 restart");
      bgn = 1'b0;
      step();
      drain("t4 restart");

      // Reset during SHIFT
      step();
      src_q.push_back(8'h99); src_q.push_back(8'h66);
      addr_bgn = 9'h010;
      data_len = 8'd2;
      bgn = 1'b1;
      repeat (10) step();
      check("t5 in shift", (n_s1 > 0) && (sel === 1'b0), 1);
      rst = 1'b1;
      step();
      check_reset_outputs("t5 reset");
      rst = 1'b0;
      bgn = 1'b0;
      repeat (3) step();
      drain("t5");
      src_q.delete();

`ifdef PSEUDO_SPI_RX_FREQ_DIV_EN
      // Stretched timing, FREQ_DIV=2
      step();
      snap();
      src_q.push_back(8'h3C);
      exp_q.push_back({9'h100, 8'h3C});
      addr_bgn = 9'h100;
      data_len = 8'd1;
      freq_div = 2'd2;
      bgn = 1'b1;
      xfer_wait(103, 1'b0, "t6");
      check("t6 sclk1 width", w1, 3);
      check("t6 sclk2 width", w2, 3);
      check("t6 sel cycles", n_sel_cyc - b_sel_cyc, 6);
      check("t6 sclk1 pulses", n_s1 - b_s1, 8);
      bgn = 1'b0;
      step();
      drain("t6");
`endif

      check("cen/d_we consistency", n_bad, 0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
